// File: rtl/gpu_mem_pkg.sv
// Shared vertex-memory definitions: responder FSM states and the vertex line stride
// used by both the responder and the fetch side.
package gpu_mem_pkg;

    localparam int unsigned LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bytes between consecutive vertex lines.
    function automatic int unsigned vertex_stride(input int unsigned attr_w,
                                                  input int unsigned attrs);
        return (attr_w * attrs) / 8;
    endfunction

endpackage

// File: rtl/vertex_sram.sv
// Vertex line storage: one write port and one registered read port, contents not reset.
module vertex_sram #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_index,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read captures the pre-write contents when both ports hit one index on the same edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_index] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_index];
        end
    end

endmodule

// File: rtl/vertex_mem_responder.sv
// Fixed-latency memory responder serving vertex lines from a host-written array.
// Decodes byte addresses into line indices and flags misaligned/out-of-range reads.
module vertex_mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int unsigned ATTR_WIDTH       = 32,
    parameter int unsigned ATTRS_PER_VERTEX = 8,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DEPTH            = 256,
    parameter int unsigned LATENCY          = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    localparam int unsigned LINE_W = ATTR_WIDTH * ATTRS_PER_VERTEX,
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_mem_req,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    output logic                  o_mem_ready,
    output logic [LINE_W-1:0]     o_mem_rdata,
    output logic                  o_mem_err,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_index,
    input  logic [LINE_W-1:0]     i_wr_data,
    output logic                  o_busy
);

    localparam int unsigned STRIDE = vertex_stride(ATTR_WIDTH, ATTRS_PER_VERTEX);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);

    state_t                 state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q;
    logic                   err_lat_q;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   latch_c;
    logic                   rd_en_c;
    logic [IDX_W-1:0]       rd_index_c;

    logic [ADDR_WIDTH-1:0]  offset_c;
    logic [ADDR_WIDTH-1:0]  index_full_c;
    logic [IDX_W-1:0]       dec_index_c;
    logic                   dec_err_c;
    logic [LINE_W-1:0]      sram_rdata;

    // Address decode; addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    assign offset_c     = i_mem_addr - BASE_ADDR;
    assign index_full_c = offset_c / STRIDE_A;
    assign dec_index_c  = IDX_W'(index_full_c);
    assign dec_err_c    = ((offset_c % STRIDE_A) != '0) || (index_full_c >= DEPTH_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, response strobes and read-port control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        busy_d     = 1'b0;
        valid_d    = valid_q;
        latch_c    = 1'b0;
        rd_en_c    = 1'b0;
        rd_index_c = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (i_mem_req) begin
                    latch_c = 1'b1;
                    busy_d  = 1'b1;
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        ready_d    = 1'b1;
                        err_d      = dec_err_c;
                        valid_d    = ~dec_err_c;
                        rd_en_c    = ~dec_err_c;
                        rd_index_c = dec_index_c;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q <= LAT_CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    err_d   = err_lat_q;
                    valid_d = ~err_lat_q;
                    rd_en_c = ~err_lat_q;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            err_lat_q <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            if (latch_c) begin
                idx_q     <= dec_index_c;
                err_lat_q <= dec_err_c;
            end
        end
    end

    vertex_sram #(
        .WIDTH (LINE_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk      (clk),
        .wr_en    (i_wr_en),
        .wr_index (i_wr_index),
        .wr_data  (i_wr_data),
        .rd_en    (rd_en_c),
        .rd_index (rd_index_c),
        .rd_data  (sram_rdata)
    );

    // The read register holds the last line; valid_q zeroes it after reset or an error response.
    assign o_mem_rdata = valid_q ? sram_rdata : '0;
    assign o_mem_ready = ready_q;
    assign o_mem_err   = err_q;
    assign o_busy      = busy_q;

endmodule

// File: doc/vertex_mem_responder.md
VERTEX_MEM_RESPONDER -- requirements
Module: vertex_mem_responder

Interface
REQ-001 Parameter ATTR_WIDTH, default 32, bits per attribute.
REQ-002 Parameter ATTRS_PER_VERTEX, default 8, attributes per vertex line.
REQ-003 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 Parameter DEPTH, default 256, number of vertex lines stored.
REQ-005 Parameter LATENCY, default 2, request-to-ready cycles, legal range 1..15.
REQ-006 Parameter BASE_ADDR, default 0, byte address of line 0.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 i_mem_req  in  1  read request, held high by initiator until ready.
REQ-010 i_mem_addr  in  ADDR_WIDTH  byte address, stable while i_mem_req high.
REQ-011 o_mem_ready  out  1  one-cycle response strobe; rdata and err valid this cycle.
REQ-012 o_mem_rdata  out  LINE_W (ATTR_WIDTH*ATTRS_PER_VERTEX)  vertex line.
REQ-013 o_mem_err  out  1  misaligned or out-of-range request, valid with o_mem_ready.
REQ-014 i_wr_en  in  1  host line write strobe.
REQ-015 i_wr_index  in  $clog2(DEPTH)  line index to write.
REQ-016 i_wr_data  in  LINE_W  line write data.
REQ-017 o_busy  out  1  high in WAIT and RESP.

Function
REQ-018 STRIDE = LINE_W/8 bytes; offset = addr - BASE_ADDR (ADDR_WIDTH modulo); index = offset/STRIDE.
REQ-019 Request is valid iff offset % STRIDE == 0 and index < DEPTH; addr below BASE_ADDR wraps and fails range.
REQ-020 FSM states IDLE, WAIT, RESP; IDLE->WAIT on i_mem_req (LATENCY>1), IDLE->RESP directly when LATENCY==1.
REQ-021 On IDLE acceptance, address decode result (index, err) is latched; later changes on i_mem_addr are ignored.
REQ-022 WAIT counts LATENCY-1 cycles then enters RESP; o_mem_ready high exactly LATENCY cycles after the accept cycle.
REQ-023 RESP lasts exactly one cycle, drives o_mem_ready=1, then returns to IDLE unconditionally.
REQ-024 o_mem_rdata register loads array[index] on the edge entering RESP; loads zero when err.
REQ-025 o_mem_rdata holds its value after RESP until the next RESP load.
REQ-026 o_mem_err is high only in RESP; low otherwise.
REQ-027 i_mem_req sampled in RESP is ignored; a new request is accepted only in IDLE (minimum one idle cycle between responses).
REQ-028 i_wr_en writes i_wr_data to i_wr_index on the edge; writes accepted in any state.
REQ-029 Write and read-capture on the same edge to the same index: read returns old data (read-before-write).
REQ-030 Write committed at least one edge before RESP entry is visible in the response.
REQ-031 i_mem_req dropped before ready: transaction still completes; ready still pulses.

Reset
REQ-032 rst_n low: state IDLE, counter 0, o_mem_ready 0, o_mem_err 0, o_mem_rdata 0, o_busy 0, immediately.
REQ-033 Reset mid-transaction aborts it with no ready pulse; array contents are not reset.
REQ-034 First request accepted on the first edge after rst_n deasserts.

Structure
REQ-035 Shared package gpu_mem_pkg holds responder state_t enum and a vertex_stride(attr_w, attrs) function also used by the fetch side.
REQ-036 Storage is sub-module vertex_sram: 1 write port, 1 registered read port, DEPTH x LINE_W, no reset.
REQ-037 Decode, FSM and counter live in vertex_mem_responder; no other sub-modules.

Verification
REQ-038 Write line 3 = 0x...A5 pattern, req addr BASE+96, LATENCY=2 -> ready one cycle, exactly 2 cycles after accept, rdata = pattern, err 0.
REQ-039 req addr BASE+100 (misaligned) -> ready after LATENCY, err 1, rdata 0; addr BASE+256*32 -> err 1.
REQ-040 Write index 5 on the same edge as RESP entry for index 5 -> old data returned; repeat request -> new data.
REQ-041 Back-to-back: req held high across ready -> second ready no earlier than LATENCY+1 cycles after the first.
REQ-042 rst_n low during WAIT -> no ready pulse, outputs 0, next request after release responds normally with preserved array data.
REQ-043 LATENCY=1 build: req cycle 0 -> ready cycle 1; connect to the existing fetch initiator and confirm o_fetch_done and vertex data match array contents.
